four_phase_rx: RTL and testbench



---
 rtl/hs_pkg.sv | 13 +
 rtl/sync_ff.sv | 21 ++
 rtl/four_phase_rx.sv | 94 +++++++++
 tb/tb_four_phase_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared types and defaults for the four-phase handshake responder.
package hs_pkg;

   // Responder handshake states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STALL  = 2'd1,
      ACK_HI = 2'd2
   } state_t;

   localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop bit synchronizer with synchronous active-high reset.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the asynchronous input through the chain
   always_ff @(posedge clk) begin
      if (reset) ff <= '0;
      else       ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/four_phase_rx.sv
// Responder end of the four-phase req/ack handshake with valid/ready output slot.
module four_phase_rx
   import hs_pkg::*;
#(
   parameter int unsigned N           = 32,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned CW          = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_in,
   input  logic [N-1:0]  data_in,
   output logic          ack_out,
   output logic [N-1:0]  data_out,
   output logic          valid_out,
   input  logic          ready_in,
   output logic          busy,
   output logic          proto_err,
   output logic [CW-1:0] xfer_count
);

   state_t state, state_nxt;
   logic   req_s;
   logic   slot_free;
   logic   capture;
   logic   set_err;

   sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (clk),
      .reset (reset),
      .d     (req_in),
      .q     (req_s)
   );

   assign slot_free = !valid_out || ready_in;

   // Next-state and capture/error decode
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      set_err   = 1'b0;
      case (state)
         IDLE: begin
            if (req_s) begin
               if (slot_free) begin
                  capture   = 1'b1;
                  state_nxt = ACK_HI;
               end else begin
                  state_nxt = STALL;
               end
            end
         end
         STALL: begin
            if (!req_s) begin
               set_err   = 1'b1;
               state_nxt = IDLE;
            end else if (slot_free) begin
               capture   = 1'b1;
               state_nxt = ACK_HI;
            end
         end
         ACK_HI: begin
            if (!req_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ack_out    <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         busy       <= 1'b0;
         proto_err  <= 1'b0;
         xfer_count <= '0;
      end else begin
         state   <= state_nxt;
         ack_out <= (state_nxt == ACK_HI);
         busy    <= (state_nxt != IDLE);
         if (set_err) proto_err <= 1'b1;
         if (capture) begin
            data_out   <= data_in;
            valid_out  <= 1'b1;
            xfer_count <= xfer_count + CW'(1);
         end else if (valid_out && ready_in) begin
            valid_out  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_four_phase_rx.sv
// Directed self-checking bench for four_phase_rx.
module tb_four_phase_rx;

   localparam int unsigned N  = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          reset4;
   logic          req_in;
   logic [N-1:0]  data_in;
   logic          ready_in;
   logic          ack_out, valid_out, busy, proto_err;
   logic [N-1:0]  data_out;
   logic [CW-1:0] xfer_count;
   logic          ack_w, valid_w, busy_w, err_w;
   logic [N-1:0]  data_w;
   logic [3:0]    xfer_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   four_phase_rx #(.N(N), .SYNC_STAGES(2), .CW(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_in     (req_in),
      .data_in    (data_in),
      .ack_out    (ack_out),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .busy       (busy),
      .proto_err  (proto_err),
      .xfer_count (xfer_count)
   );

   four_phase_rx #(.N(N), .SYNC_STAGES(2), .CW(4)) dut_w (
      .clk        (clk),
      .reset      (reset4),
      .req_in     (req_in),
      .data_in    (data_in),
      .ack_out    (ack_w),
      .data_out   (data_w),
      .valid_out  (valid_w),
      .ready_in   (ready_in),
      .busy       (busy_w),
      .proto_err  (err_w),
      .xfer_count (xfer_w)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete four-phase cycle with bounded waits on ack
   task automatic do_xfer(input logic [N-1:0] d, input string tag);
      int n;
      data_in = d;
      req_in  = 1'b1;
      n = 0;
      while (!ack_out && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_ack_rise"}, 64'(ack_out), 64'd1);
      chk({tag, "_data"}, 64'(data_out), 64'(d));
      req_in = 1'b0;
      n = 0;
      while (ack_out && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_ack_fall"}, 64'(ack_out), 64'd0);
   endtask

   initial begin
      reset    = 1'b1;
      reset4   = 1'b1;
      req_in   = 1'b0;
      data_in  = '0;
      ready_in = 1'b1;
      step(3);
      reset = 1'b0;
      step();

      // Reset values
      chk("rst_ack",   64'(ack_out),    64'd0);
      chk("rst_data",  64'(data_out),   64'd0);
      chk("rst_valid", 64'(valid_out),  64'd0);
      chk("rst_busy",  64'(busy),       64'd0);
      chk("rst_err",   64'(proto_err),  64'd0);
      chk("rst_count", 64'(xfer_count), 64'd0);

      // Basic transfer with exact two-stage latency
      data_in = 32'hDEADBEEF;
      req_in  = 1'b1;
      step(2);
      chk("basic_ack_early", 64'(ack_out), 64'd0);
      step();
      chk("basic_ack",   64'(ack_out),    64'd1);
      chk("basic_valid", 64'(valid_out),  64'd1);
      chk("basic_data",  64'(data_out),   64'hDEADBEEF);
      chk("basic_busy",  64'(busy),       64'd1);
      chk("basic_count", 64'(xfer_count), 64'd1);
      step();
      chk("basic_consumed", 64'(valid_out), 64'd0);
      chk("basic_ack_hold", 64'(ack_out),   64'd1);
      req_in = 1'b0;
      step(2);
      chk("basic_ack_late", 64'(ack_out), 64'd1);
      step();
      chk("basic_ack_low", 64'(ack_out), 64'd0);
      chk("basic_idle",    64'(busy),    64'd0);

      // Backpressure: slot occupied stalls the handshake
      ready_in = 1'b0;
      do_xfer(32'h11111111, "bp_first");
      chk("bp_first_valid", 64'(valid_out), 64'd1);
      data_in = 32'h22222222;
      req_in  = 1'b1;
      step(4);
      chk("bp_stall_busy",  64'(busy),      64'd1);
      chk("bp_stall_ack",   64'(ack_out),   64'd0);
      chk("bp_stall_data",  64'(data_out),  64'h11111111);
      chk("bp_stall_valid", 64'(valid_out), 64'd1);
      ready_in = 1'b1;
      step();
      ready_in = 1'b0;
      chk("bp_cap_data",  64'(data_out),   64'h22222222);
      chk("bp_cap_valid", 64'(valid_out),  64'd1);
      chk("bp_cap_ack",   64'(ack_out),    64'd1);
      chk("bp_cap_count", 64'(xfer_count), 64'd3);
      req_in = 1'b0;
      step(4);
      chk("bp_done_ack", 64'(ack_out), 64'd0);

      // Protocol violation: req withdrawn while stalled
      data_in = 32'h33333333;
      req_in  = 1'b1;
      step(4);
      chk("pe_stall", 64'(busy), 64'd1);
      req_in = 1'b0;
      step(3);
      chk("pe_err",   64'(proto_err),  64'd1);
      chk("pe_idle",  64'(busy),       64'd0);
      chk("pe_count", 64'(xfer_count), 64'd3);
      chk("pe_data",  64'(data_out),   64'h22222222);
      ready_in = 1'b1;
      do_xfer(32'h44444444, "pe_next");
      chk("pe_next_count", 64'(xfer_count), 64'd4);
      chk("pe_sticky",     64'(proto_err),  64'd1);

      // Back-to-back transfers, one capture per cycle
      for (int i = 1; i <= 5; i++) begin
         do_xfer(32'(i), "b2b");
         chk("b2b_count", 64'(xfer_count), 64'(4 + i));
      end

      // Reset during ACK_HI with req held high across it
      data_in = 32'h55555555;
      req_in  = 1'b1;
      step(3);
      chk("mr_ack_pre", 64'(ack_out), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_ack",   64'(ack_out),    64'd0);
      chk("mr_valid", 64'(valid_out),  64'd0);
      chk("mr_data",  64'(data_out),   64'd0);
      chk("mr_busy",  64'(busy),       64'd0);
      chk("mr_err",   64'(proto_err),  64'd0);
      chk("mr_count", 64'(xfer_count), 64'd0);
      step(2);
      chk("mr_ack_early", 64'(ack_out), 64'd1 - 64'd1);
      step();
      chk("mr_recap_ack",   64'(ack_out),    64'd1);
      chk("mr_recap_data",  64'(data_out),   64'h55555555);
      chk("mr_recap_count", 64'(xfer_count), 64'd1);
      req_in = 1'b0;
      step(4);

      // 4-bit counter wraps after 16 captures
      reset4 = 1'b0;
      step();
      for (int i = 0; i < 17; i++) begin
         do_xfer(32'(32'hA0 + i), "wrap");
      end
      chk("wrap_count4",  64'(xfer_w),     64'd1);
      chk("wrap_count16", 64'(xfer_count), 64'd18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
